bsg_axil_to_fifo_client: RTL and testbench

//  AXI4-Lite subordinate that terminates the AXI-Lite manager port driven by the cosim DPI bridge
//  (or the PS GP port on hardware). It converts each AXI-Lite read or write into a single request
//  on a valid/ready client interface. Read data returns on a valid/yumi response interface.

---
 rtl/bsg_axil_to_fifo_client.sv | 179 +++++++++++++++++
 tb/tb_bsg_axil_to_fifo_client.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_axil_to_fifo_client.sv
// AXI4-Lite subordinate that turns each AXI-Lite read or write into one valid/ready client request.
// Read data comes back on a valid/yumi interface. Only one transaction is in flight at a time.
module bsg_axil_to_fifo_client #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
) (
  input  logic                        aclk_i,
  input  logic                        areset_i,
  input  logic [addr_width_p-1:0]     awaddr_i,
  input  logic [2:0]                  awprot_i,
  input  logic                        awvalid_i,
  output logic                        awready_o,
  input  logic [data_width_p-1:0]     wdata_i,
  input  logic [data_width_p/8-1:0]   wstrb_i,
  input  logic                        wvalid_i,
  output logic                        wready_o,
  output logic [1:0]                  bresp_o,
  output logic                        bvalid_o,
  input  logic                        bready_i,
  input  logic [addr_width_p-1:0]     araddr_i,
  input  logic [2:0]                  arprot_i,
  input  logic                        arvalid_i,
  output logic                        arready_o,
  output logic [data_width_p-1:0]     rdata_o,
  output logic [1:0]                  rresp_o,
  output logic                        rvalid_o,
  input  logic                        rready_i,
  output logic                        v_o,
  output logic                        w_o,
  output logic [addr_width_p-1:0]     addr_o,
  output logic [data_width_p-1:0]     data_o,
  output logic [data_width_p/8-1:0]   wmask_o,
  input  logic                        ready_i,
  input  logic                        v_i,
  input  logic [data_width_p-1:0]     data_i,
  output logic                        yumi_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RD_RESP = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic                      aw_full_q, w_full_q, ar_full_q;
  logic [addr_width_p-1:0]   aw_addr_q, ar_addr_q;
  logic [data_width_p-1:0]   w_data_q, rdata_q;
  logic [data_width_p/8-1:0] w_mask_q;
  logic                      last_wr_q;
  logic                      wr_done_s, rd_done_s, rd_capture_s;
  logic                      wr_ok_s, rd_ok_s;
  logic                      prot_unused_s;

  assign prot_unused_s = ^{awprot_i, arprot_i};

  assign wr_ok_s   = aw_full_q & w_full_q;
  assign rd_ok_s   = ar_full_q;
  assign awready_o = ~aw_full_q;
  assign wready_o  = ~w_full_q;
  assign arready_o = ~ar_full_q;
  assign bresp_o   = 2'b00;
  assign rresp_o   = 2'b00;
  assign rdata_o   = rdata_q;

  // Next-state and client/response outputs, decoded from the current state.
  always_comb begin
    state_d      = state_q;
    v_o          = 1'b0;
    w_o          = 1'b0;
    addr_o       = '0;
    data_o       = '0;
    wmask_o      = '0;
    bvalid_o     = 1'b0;
    rvalid_o     = 1'b0;
    yumi_o       = 1'b0;
    wr_done_s    = 1'b0;
    rd_done_s    = 1'b0;
    rd_capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        // Simultaneous read/write alternates on last_wr so neither side starves.
        if (wr_ok_s & rd_ok_s) state_d = last_wr_q ? RD_REQ : WR_REQ;
        else if (wr_ok_s)      state_d = WR_REQ;
        else if (rd_ok_s)      state_d = RD_REQ;
        else                   state_d = IDLE;
      end
      WR_REQ: begin
        v_o     = 1'b1;
        w_o     = 1'b1;
        addr_o  = aw_addr_q;
        data_o  = w_data_q;
        wmask_o = w_mask_q;
        if (ready_i) begin
          wr_done_s = 1'b1;
          state_d   = WR_RESP;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) state_d = IDLE;
        else          state_d = WR_RESP;
      end
      RD_REQ: begin
        v_o    = 1'b1;
        addr_o = ar_addr_q;
        if (ready_i) begin
          rd_done_s = 1'b1;
          state_d   = RD_WAIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        yumi_o = v_i;
        if (v_i) begin
          rd_capture_s = 1'b1;
          state_d      = RD_RESP;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_RESP: begin
        rvalid_o = 1'b1;
        if (rready_i) state_d = IDLE;
        else          state_d = RD_RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, skid registers, arbitration flag and read data capture.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q   <= IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_mask_q  <= '0;
      last_wr_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      // A register being cleared still shows ready low, so clear never races a refill.
      if (wr_done_s) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        last_wr_q <= 1'b1;
      end else begin
        if (awvalid_i & ~aw_full_q) begin
          aw_full_q <= 1'b1;
          aw_addr_q <= awaddr_i;
        end
        if (wvalid_i & ~w_full_q) begin
          w_full_q <= 1'b1;
          w_data_q <= wdata_i;
          w_mask_q <= wstrb_i;
        end
      end
      if (rd_done_s) begin
        ar_full_q <= 1'b0;
        last_wr_q <= 1'b0;
      end else if (arvalid_i & ~ar_full_q) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= araddr_i;
      end
      if (rd_capture_s) rdata_q <= data_i;
    end
  end

endmodule

// File: tb/tb_bsg_axil_to_fifo_client.sv
// Self-checking bench for bsg_axil_to_fifo_client: a scoreboard of expected client requests,
// write responses and read data, plus cycle-accurate latency and hold checks.
module tb_bsg_axil_to_fifo_client;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          aclk_i = 1'b0;
  logic          areset_i;
  logic [AW-1:0] awaddr_i, araddr_i, addr_o;
  logic          awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;
  logic          arvalid_i, arready_o, rvalid_o, rready_i;
  logic [DW-1:0] wdata_i, rdata_o, data_o, data_i;
  logic [MW-1:0] wstrb_i, wmask_o;
  logic [1:0]    bresp_o, rresp_o;
  logic          v_o, w_o, ready_i, v_i, yumi_o;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } req_t;

  req_t          req_q[$];
  logic [DW-1:0] rd_q[$];
  int            b_pend   = 0;
  int            n_cmp    = 0;
  int            n_err    = 0;
  int            yumi_cnt = 0;
  int            y0;

  always #5 aclk_i = ~aclk_i;

  bsg_axil_to_fifo_client #(.addr_width_p(AW), .data_width_p(DW)) dut (
    .aclk_i(aclk_i), .areset_i(areset_i),
    .awaddr_i(awaddr_i), .awprot_i(3'b000), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arprot_i(3'b000), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .v_o(v_o), .w_o(w_o), .addr_o(addr_o), .data_o(data_o), .wmask_o(wmask_o),
    .ready_i(ready_i), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk_i);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((req_q.size() != 0 || rd_q.size() != 0 || b_pend != 0) && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < 100), 64'd1);
  endtask

  // Scoreboard monitor: compares every accepted request and every B/R handshake.
  initial begin
    req_t e;
    forever begin
      @(negedge aclk_i);
      if (!areset_i) begin
        if (v_o && ready_i) begin
          chk("req_expected", 64'(req_q.size() > 0), 64'd1);
          if (req_q.size() > 0) begin
            e = req_q.pop_front();
            chk("req_w", 64'(w_o), 64'(e.w));
            chk("req_addr", 64'(addr_o), 64'(e.addr));
            chk("req_data", 64'(data_o), 64'(e.data));
            chk("req_mask", 64'(wmask_o), 64'(e.mask));
          end
        end
        if (bvalid_o && bready_i) begin
          chk("b_expected", 64'(b_pend > 0), 64'd1);
          b_pend--;
          chk("bresp", 64'(bresp_o), 64'd0);
        end
        if (rvalid_o && rready_i) begin
          chk("r_expected", 64'(rd_q.size() > 0), 64'd1);
          if (rd_q.size() > 0) chk("rdata", 64'(rdata_o), 64'(rd_q.pop_front()));
          chk("rresp", 64'(rresp_o), 64'd0);
        end
        if (yumi_o) yumi_cnt++;
      end
    end
  end

  initial begin
    areset_i = 1'b1;
    awaddr_i = '0; awvalid_i = 1'b0; wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0;
    araddr_i = '0; arvalid_i = 1'b0; bready_i = 1'b1; rready_i = 1'b1;
    ready_i = 1'b1; v_i = 1'b0; data_i = '0;
    tick(); tick();
    chk("rst_v", 64'(v_o), 64'd0);
    chk("rst_bvalid", 64'(bvalid_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_yumi", 64'(yumi_o), 64'd0);
    chk("rst_awready", 64'(awready_o), 64'd1);
    chk("rst_wready", 64'(wready_o), 64'd1);
    chk("rst_arready", 64'(arready_o), 64'd1);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    areset_i = 1'b0;
    tick();

    // 1: AW+W together, minimum latency
    awaddr_i = 16'h0010; awvalid_i = 1'b1; wdata_i = 32'hDEADBEEF; wstrb_i = 4'hF; wvalid_i = 1'b1;
    req_q.push_back(req_t'{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF}); b_pend++;
    chk("t1_awready", 64'(awready_o), 64'd1);
    tick(); awvalid_i = 1'b0; wvalid_i = 1'b0;
    chk("t1_c1_v", 64'(v_o), 64'd0);
    chk("t1_c1_awready", 64'(awready_o), 64'd0);
    tick();
    chk("t1_c2_v", 64'(v_o), 64'd1);
    chk("t1_c2_w", 64'(w_o), 64'd1);
    chk("t1_c2_addr", 64'(addr_o), 64'h10);
    chk("t1_c2_data", 64'(data_o), 64'hDEADBEEF);
    chk("t1_c2_bvalid", 64'(bvalid_o), 64'd0);
    tick();
    chk("t1_c3_bvalid", 64'(bvalid_o), 64'd1);
    chk("t1_c3_v", 64'(v_o), 64'd0);
    chk("t1_c3_awready", 64'(awready_o), 64'd1);
    tick();
    chk("t1_c4_bvalid", 64'(bvalid_o), 64'd0);

    // 2: W five cycles before AW
    wdata_i = 32'hCAFEF00D; wstrb_i = 4'h3; wvalid_i = 1'b1;
    tick(); wvalid_i = 1'b0;
    chk("t2_wready", 64'(wready_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_no_v", 64'(v_o), 64'd0);
      tick();
    end
    awaddr_i = 16'h0044; awvalid_i = 1'b1;
    req_q.push_back(req_t'{1'b1, 16'h0044, 32'hCAFEF00D, 4'h3}); b_pend++;
    tick(); awvalid_i = 1'b0;
    chk("t2_c1_v", 64'(v_o), 64'd0);
    tick();
    chk("t2_c2_v", 64'(v_o), 64'd1);
    drain("t2_drain");

    // 3: read with held rready
    rready_i = 1'b0; y0 = yumi_cnt;
    araddr_i = 16'h0020; arvalid_i = 1'b1;
    req_q.push_back(req_t'{1'b0, 16'h0020, 32'h0, 4'h0}); rd_q.push_back(32'h12345678);
    tick(); arvalid_i = 1'b0;
    chk("t3_arready", 64'(arready_o), 64'd0);
    tick();
    chk("t3_c2_v", 64'(v_o), 64'd1);
    chk("t3_c2_w", 64'(w_o), 64'd0);
    tick();
    v_i = 1'b1; data_i = 32'h12345678;
    #1 chk("t3_yumi", 64'(yumi_o), 64'd1);
    tick(); v_i = 1'b0; data_i = 32'hFFFF0000;
    for (int i = 0; i < 4; i++) begin
      chk("t3_rvalid_hold", 64'(rvalid_o), 64'd1);
      chk("t3_rdata_hold", 64'(rdata_o), 64'h12345678);
      chk("t3_no_v", 64'(v_o), 64'd0);
      tick();
    end
    rready_i = 1'b1;
    tick();
    chk("t3_rvalid_done", 64'(rvalid_o), 64'd0);
    chk("t3_yumi_once", 64'(yumi_cnt - y0), 64'd1);

    // 4: arbitration, write first after a read, read first after a write
    y0 = yumi_cnt; v_i = 1'b1; data_i = 32'hA5A50001;
    awaddr_i = 16'h0060; awvalid_i = 1'b1; wdata_i = 32'h11112222; wstrb_i = 4'hF; wvalid_i = 1'b1;
    araddr_i = 16'h0064; arvalid_i = 1'b1;
    req_q.push_back(req_t'{1'b1, 16'h0060, 32'h11112222, 4'hF}); b_pend++;
    req_q.push_back(req_t'{1'b0, 16'h0064, 32'h0, 4'h0}); rd_q.push_back(32'hA5A50001);
    tick(); awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    drain("t4_pair_a");
    awaddr_i = 16'h0068; awvalid_i = 1'b1; wdata_i = 32'h33334444; wvalid_i = 1'b1;
    req_q.push_back(req_t'{1'b1, 16'h0068, 32'h33334444, 4'hF}); b_pend++;
    tick(); awvalid_i = 1'b0; wvalid_i = 1'b0;
    drain("t4_single_wr");
    data_i = 32'hA5A50002;
    awaddr_i = 16'h006C; awvalid_i = 1'b1; wdata_i = 32'h55556666; wvalid_i = 1'b1;
    araddr_i = 16'h0070; arvalid_i = 1'b1;
    req_q.push_back(req_t'{1'b0, 16'h0070, 32'h0, 4'h0}); rd_q.push_back(32'hA5A50002);
    req_q.push_back(req_t'{1'b1, 16'h006C, 32'h55556666, 4'hF}); b_pend++;
    tick(); awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    drain("t4_pair_b");
    v_i = 1'b0;
    chk("t4_yumi_count", 64'(yumi_cnt - y0), 64'd2);

    // 5: client stalls a write for 10 cycles
    ready_i = 1'b0;
    awaddr_i = 16'h0030; awvalid_i = 1'b1; wdata_i = 32'h0BADF00D; wstrb_i = 4'hC; wvalid_i = 1'b1;
    req_q.push_back(req_t'{1'b1, 16'h0030, 32'h0BADF00D, 4'hC}); b_pend++;
    tick(); awvalid_i = 1'b0; wvalid_i = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t5_v_hold", 64'(v_o), 64'd1);
      chk("t5_addr_hold", 64'(addr_o), 64'h30);
      chk("t5_data_hold", 64'(data_o), 64'h0BADF00D);
      chk("t5_no_bvalid", 64'(bvalid_o), 64'd0);
      tick();
    end
    ready_i = 1'b1;
    tick();
    chk("t5_bvalid", 64'(bvalid_o), 64'd1);
    tick();
    chk("t5_bvalid_done", 64'(bvalid_o), 64'd0);

    // 6: reset while waiting for read data
    araddr_i = 16'h0050; arvalid_i = 1'b1;
    req_q.push_back(req_t'{1'b0, 16'h0050, 32'h0, 4'h0});
    tick(); arvalid_i = 1'b0;
    tick();
    tick();
    chk("t6_wait_rvalid", 64'(rvalid_o), 64'd0);
    areset_i = 1'b1;
    tick();
    chk("t6_rst_v", 64'(v_o), 64'd0);
    chk("t6_rst_bvalid", 64'(bvalid_o), 64'd0);
    chk("t6_rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("t6_rst_readies", 64'({awready_o, wready_o, arready_o}), 64'd7);
    v_i = 1'b1;
    #1 chk("t6_rst_yumi", 64'(yumi_o), 64'd0);
    areset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stray_yumi", 64'(yumi_o), 64'd0);
      chk("t6_no_rvalid", 64'(rvalid_o), 64'd0);
      chk("t6_no_v", 64'(v_o), 64'd0);
    end
    v_i = 1'b0;

    chk("end_req_q", 64'(req_q.size()), 64'd0);
    chk("end_rd_q", 64'(rd_q.size()), 64'd0);
    chk("end_b_pend", 64'(b_pend), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
